// File: rtl/fifo_flagged.sv
`default_nettype none
// ============================================================================
// Module     : fifo_flagged
// Description: Register-file FIFO with occupancy count, almost-full/empty
//              thresholds and sticky overflow/underflow flags. Define
//              FIFO_FWFT_EN for first-word-fall-through reads.
// Revision   : 1.0 - initial release
// ============================================================================
module fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;

    // Flags depend on the count register only, never on rd/wr.
    assign full         = (count_q == C_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase

        if (wr & ~wr_acc)  overflow_d = 1'b1;
        else if (clr_err)  overflow_d = 1'b0;

        if (rd & ~rd_acc)  underflow_d = 1'b1;
        else if (clr_err)  underflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a write in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_acc) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_flagged.sv
`default_nettype none
// ============================================================================
// Module     : tb_fifo_flagged
// Description: Self-checking bench for fifo_flagged (DEPTH=4) against a
//              queue-based reference model; directed plan plus random traffic.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fifo_flagged;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   af_thresh = 3'd3;
    logic [AW:0]   ae_thresh = 3'd1;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rd_data;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;

    fifo_flagged #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd           (rd),
        .wr           (wr),
        .wr_data      (wr_data),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents as a queue, sticky flags, last popped word.
    logic [DW-1:0] mq[$];
    logic          m_ov = 1'b0;
    logic          m_un = 1'b0;
    logic [DW-1:0] m_last = '0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            m_ov   = 1'b0;
            m_un   = 1'b0;
            m_last = '0;
            chk_en = 1'b1;
        end else begin
            bit r_ok, w_ok;
            r_ok = rd && (mq.size() != 0);
            w_ok = wr && ((mq.size() < DEPTH) || r_ok);
            if (r_ok) m_last = mq.pop_front();
            if (w_ok) mq.push_back(wr_data);
            if (wr && !w_ok)   m_ov = 1'b1;
            else if (clr_err)  m_ov = 1'b0;
            if (rd && !r_ok)   m_un = 1'b1;
            else if (clr_err)  m_un = 1'b0;
        end
    end

    function automatic logic [DW-1:0] exp_rd_data();
`ifdef FIFO_FWFT_EN
        return (mq.size() != 0) ? mq[0] : '0;
`else
        return m_last;
`endif
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = mq.size();
            cmp("count",        int'(count),        n);
            cmp("empty",        int'(empty),        int'(n == 0));
            cmp("full",         int'(full),         int'(n == DEPTH));
            cmp("almost_full",  int'(almost_full),  int'(n >= int'(af_thresh)));
            cmp("almost_empty", int'(almost_empty), int'(n <= int'(ae_thresh)));
            cmp("overflow",     int'(overflow),     int'(m_ov));
            cmp("underflow",    int'(underflow),    int'(m_un));
            cmp("rd_data",      int'(rd_data),      int'(exp_rd_data()));
        end
    end

    // Apply one cycle of inputs and return just after the edge that uses them.
    task automatic tick(input logic r, input logic w, input logic [DW-1:0] d,
                        input logic c, input logic rst_n);
        @(negedge clk);
        #1;
        rd = r; wr = w; wr_data = d; clr_err = c; reset = rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        tick(1'b0, 1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    // Pop (optionally with a push) and pin the returned word to a literal.
    task automatic pop_check(input string name, input logic [DW-1:0] exp,
                             input logic w, input logic [DW-1:0] d);
`ifdef FIFO_FWFT_EN
        cmp(name, int'(rd_data), int'(exp));
        tick(1'b1, w, d, 1'b0, 1'b1);
`else
        tick(1'b1, w, d, 1'b0, 1'b1);
        cmp(name, int'(rd_data), int'(exp));
`endif
    endtask

    initial begin
        // Reset state
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cmp("rst_count", int'(count), 0);
        cmp("rst_empty", int'(empty), 1);
        cmp("rst_full",  int'(full),  0);
        cmp("rst_ae",    int'(almost_empty), 1);
        cmp("rst_af",    int'(almost_full),  0);
        cmp("rst_rd_data", int'(rd_data), 0);

        // Fill to full
        push(8'hA1); cmp("fill1_count", int'(count), 1); cmp("fill1_ae", int'(almost_empty), 1);
        push(8'hB2); cmp("fill2_count", int'(count), 2); cmp("fill2_ae", int'(almost_empty), 0);
        push(8'hC3); cmp("fill3_count", int'(count), 3); cmp("fill3_af", int'(almost_full), 1);
        push(8'hD4); cmp("fill4_count", int'(count), 4); cmp("fill4_full", int'(full), 1);
        cmp("fill4_ovf", int'(overflow), 0);

        // Overflow while full, sticky until clr_err
        push(8'hEE); cmp("ovf_set", int'(overflow), 1); cmp("ovf_count", int'(count), 4);
        idle();      cmp("ovf_sticky", int'(overflow), 1);
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1); cmp("ovf_clr", int'(overflow), 0);

        // Simultaneous pop and push while full
        pop_check("full_rdwr_data", 8'hA1, 1'b1, 8'h55);
        cmp("full_rdwr_count", int'(count), 4);
        cmp("full_rdwr_full",  int'(full), 1);
        pop_check("pop_b2", 8'hB2, 1'b0, '0);
        pop_check("pop_c3", 8'hC3, 1'b0, '0);
        pop_check("pop_d4", 8'hD4, 1'b0, '0);
        pop_check("pop_55", 8'h55, 1'b0, '0);
        cmp("drain_empty", int'(empty), 1);

        // Empty with rd and wr: write only, underflow set; set beats clear
        tick(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        cmp("empty_rdwr_count", int'(count), 1);
        cmp("empty_rdwr_unf",   int'(underflow), 1);
        pop_check("pop_77", 8'h77, 1'b0, '0);
        cmp("pop_77_empty", int'(empty), 1);
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cmp("unf_clr", int'(underflow), 0);

        // Wrap-around with occupancy <= 2
        for (int i = 0; i < 10; i++) begin
            push(DW'(i));
            pop_check("wrap_data", DW'(i), 1'b0, '0);
        end
        cmp("wrap_ovf", int'(overflow), 0);
        cmp("wrap_unf", int'(underflow), 0);

        // Reset mid-operation with count=3 and flags set
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        pop_check("pre_rst_pop", 8'h11, 1'b0, '0);
        cmp("pre_rst_count", int'(count), 3);
        cmp("pre_rst_ovf", int'(overflow), 1);
        tick(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        cmp("mid_rst_count", int'(count), 0);
        cmp("mid_rst_empty", int'(empty), 1);
        cmp("mid_rst_rd_data", int'(rd_data), 0);
        cmp("mid_rst_ovf", int'(overflow), 0);

        // Threshold corners
        af_thresh = 3'd0; ae_thresh = 3'd4;
        push(8'h01); cmp("af_zero", int'(almost_full), 1);
        push(8'h02); push(8'h03); push(8'h04);
        cmp("ae_ge_depth", int'(almost_empty), 1);

        // Random traffic with random thresholds
        for (int i = 0; i < 3000; i++) begin
            logic r, w, c, rn;
            r  = ($urandom_range(0, 99) < 50);
            w  = ($urandom_range(0, 99) < 55);
            c  = ($urandom_range(0, 99) < 5);
            rn = ($urandom_range(0, 299) != 0);
            af_thresh = AW'($urandom_range(0, 7)) == '0 ? 3'(0) : 3'($urandom_range(0, 7));
            ae_thresh = 3'($urandom_range(0, 7));
            tick(r, w, DW'($urandom), c, rn);
        end
        idle();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
